// File: rtl/uart_cmd_rcv.sv
// Serial receiver for 24-bit host commands sent as three 8N1 bytes, MSB byte first.
// Assembles each command and holds it with a sticky ready flag until the dispatcher acknowledges it.
module uart_cmd_rcv #(
    parameter int BAUD_DIV = 2604,
    parameter int TIMEOUT  = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    input  logic        clr_cmd_rdy,
    output logic [23:0] cmd,
    output logic        cmd_rdy,
    output logic        frm_err,
    output logic        ovr
);

    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [31:0]      TO_LAST   = 32'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

    rx_state_t        state;
    logic             rx_meta, rx_sync;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic [1:0]       byte_cnt;
    logic [7:0]       hi, mid;
    logic [31:0]      idle_cnt;
    logic             stop_sample, byte_vld, stop_bad;

    // Preset high so reset release never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_sync <= rx_meta;
        end
    end

    always_comb begin
        stop_sample = (state == STOP) && (cnt == FULL_LAST);
        byte_vld    = stop_sample && rx_sync;
        stop_bad    = stop_sample && !rx_sync;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            frm_err <= 1'b0;
        end else begin
            frm_err <= stop_bad;
            case (state)
                IDLE: begin
                    if (!rx_sync) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_sync ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == FULL_LAST) begin
                        cnt     <= '0;
                        shreg   <= {rx_sync, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) state <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == FULL_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Byte assembler, inter-byte timeout and ready/overrun handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt <= '0;
            hi       <= '0;
            mid      <= '0;
            idle_cnt <= '0;
            cmd      <= '0;
            cmd_rdy  <= 1'b0;
            ovr      <= 1'b0;
        end else begin
            ovr <= 1'b0;
            // NOTE: the clear is written first so a completion later in this block overrides it (set wins).
            if (clr_cmd_rdy) cmd_rdy <= 1'b0;
            if (stop_bad) begin
                byte_cnt <= '0;
                idle_cnt <= '0;
            end else if (byte_vld) begin
                idle_cnt <= '0;
                case (byte_cnt)
                    2'd0: begin
                        hi       <= shreg;
                        byte_cnt <= 2'd1;
                    end
                    2'd1: begin
                        mid      <= shreg;
                        byte_cnt <= 2'd2;
                    end
                    default: begin
                        cmd      <= {hi, mid, shreg};
                        cmd_rdy  <= 1'b1;
                        ovr      <= cmd_rdy && !clr_cmd_rdy;
                        byte_cnt <= 2'd0;
                    end
                endcase
            end else if (byte_cnt != 2'd0) begin
                if (idle_cnt == TO_LAST) begin
                    byte_cnt <= '0;
                    idle_cnt <= '0;
                end else begin
                    idle_cnt <= idle_cnt + 32'd1;
                end
            end else begin
                idle_cnt <= '0;
            end
        end
    end

endmodule
